obi_cache_master: RTL
=====================

Name: obi_cache_master

Overview:
- OBI initiator that drives the cache's OBI target interface from a local command port.
- Takes one cache command (op, key, value) on a valid/ready port and serializes it into single-word OBI writes. The order is value words, then key words, then the op word, which triggers the target.
- For read operations it then issues OBI reads to collect the returned value.
- Returns value plus error status on a result valid/ready port; used by test harnesses and on-chip clients that sit on the master side of the cache.

Parameters:
- ADDR_WIDTH, 32, OBI address width.
- DATA_WIDTH, 32, OBI data width (one beat = one word).
- KEY_WIDTH, 32, command key width; integer multiple of DATA_WIDTH.
- VALUE_WIDTH, 64, command value width; integer multiple of DATA_WIDTH.
- OP_WIDTH, 2, operation code width; zero-extended into one data word.
- OP_READ, 1, op code that causes value read-back.
- VALUE_BASE, 0, byte address of value word 0; word i at VALUE_BASE+4*i.
- KEY_BASE, 8, byte address of key word 0; word i at KEY_BASE+4*i.
- OP_ADDR, 12, byte address of the op word.
- TIMEOUT_CYCLES, 255, response timeout; used only with the optional feature.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when cmd_valid & cmd_ready.
- cmd_op, in, OP_WIDTH, operation code.
- cmd_key, in, KEY_WIDTH, key.
- cmd_value, in, VALUE_WIDTH, value to store.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, result consumed when rsp_valid & rsp_ready.
- rsp_value, out, VALUE_WIDTH, read-back value; 0 for non-read ops.
- rsp_err, out, 1, OR of err across all beats of the command.
- rsp_timeout, out, 1, timeout abort flag; tied 0 without the optional feature.
- obi_req, out, 1, OBI A-channel request.
- obi_gnt, in, 1, OBI grant.
- obi_addr, out, ADDR_WIDTH, byte address.
- obi_we, out, 1, 1 = write.
- obi_be, out, DATA_WIDTH/8, byte enables; always all ones.
- obi_wdata, out, DATA_WIDTH, write data.
- obi_rvalid, in, 1, OBI R-channel valid.
- obi_rready, out, 1, master ready for response.
- obi_rdata, in, DATA_WIDTH, read data.
- obi_err, in, 1, response error.

Interface:
- One clock (clk); reset is synchronous and active-high (rst).

Behaviour:
- **Reset:** while rst is high at a clk edge:
  - state goes to IDLE.
  - All outputs go to 0, except cmd_ready = 1 and obi_be = all ones.
  - Captured command, beat counter and response registers clear.
  - Reset mid-transaction abandons the beat with no completion; the target is reset together with the master.
- **Derived counts:** NV = VALUE_WIDTH/DATA_WIDTH, NK = KEY_WIDTH/DATA_WIDTH.
- **IDLE:**
  - cmd_ready = 1.
  - On cmd_valid, capture op, key and value; clear accumulated err and rsp_value.
  - Go to ADDR with beat sequence:
    - op == OP_READ: NK key writes, 1 op write, NV reads.
    - otherwise: NV value writes, NK key writes, 1 op write.
- **ADDR:**
  - obi_req = 1 with addr/we/wdata for the current beat; these are held stable until obi_gnt.
  - Writes use the word slice [i*DATA_WIDTH +: DATA_WIDTH], low word first; the op word is zero-extended.
  - On obi_req & obi_gnt, go to RESP; obi_req drops the next cycle.
  - First obi_req rises the cycle after command acceptance.
- **RESP:**
  - obi_rready = 1; obi_req = 0, so at most one outstanding transaction.
  - On obi_rvalid: OR obi_err into err. For read beats, store obi_rdata into rsp_value word i.
  - If more beats remain, advance the counter and return to ADDR; otherwise go to DONE.
  - rvalid arriving in the same cycle as gnt belongs to the next RESP cycle; the target must not respond before gnt.
- **DONE:**
  - rsp_valid = 1; rsp_value, rsp_err and rsp_timeout are stable.
  - On rsp_ready, go to IDLE. cmd_ready rises the next cycle, so there is no back-to-back accept in the DONE cycle.
- **Errors:** an error on any beat does not abort the sequence; all beats are still issued.
- **Minimum latency with gnt and rvalid each after 1 cycle:** 2 cycles per beat; write op with NV=2, NK=1 gives rsp_valid 8 cycles after accept.
- **Unknown state:** any illegal state encoding returns to IDLE.

Optional Feature:
- Macro: OBI_CACHE_MASTER_TIMEOUT_EN.
- **Defined:**
  - An 8+ bit counter runs in ADDR and RESP and resets on each state entry.
  - If it reaches TIMEOUT_CYCLES without gnt or rvalid, the command aborts: go to DONE with rsp_err = 1 and rsp_timeout = 1; remaining beats are skipped.
  - obi_req drops on abort.
- **Undefined:** no counter; rsp_timeout is constant 0; the master waits indefinitely.

Test Plan:
- **Write op:** op=2, key=0xA5A5_0001, value=0x1111_2222_3333_4444; target grants and responds after 1 cycle.
  - Writes in order: addr 0 data 0x3333_4444, addr 4 data 0x1111_2222, addr 8 data 0xA5A5_0001, addr 12 data 0x2.
  - rsp_valid 8 cycles after accept, rsp_err=0, rsp_value=0.
- **Read op:** op=1, key=0x42; target returns 0xDEAD_BEEF then 0xCAFE_F00D on the reads.
  - Writes only to addr 8 and addr 12, then reads at addr 0 and addr 4.
  - rsp_value=0xCAFE_F00D_DEAD_BEEF.
- **Grant stall and error:** gnt delayed 5 cycles on the key beat, and obi_err=1 on the op beat.
  - obi_addr and obi_wdata stable through the stall.
  - All beats still issued; rsp_err=1.
- **Response backpressure:** rsp_ready held 0 for 4 cycles, with cmd_valid already high for the next command.
  - rsp_valid and rsp_value stable; cmd_ready=0 until the cycle after the rsp handshake.
- **Reset mid-transaction:** rst asserted 1 cycle while in RESP of the key beat.
  - Next cycle: obi_req=0, rsp_valid=0, cmd_ready=1; the following command runs normally.
- **Timeout (macro defined, TIMEOUT_CYCLES=10):** target never asserts gnt.
  - obi_req drops after 10 cycles; rsp_valid=1, rsp_err=1, rsp_timeout=1.

Source files
------------

// File: rtl/obi_cache_master_if.sv
// Bundle of the command, result and OBI signals of obi_cache_master.
// master = the cache master's view; slave = the client/target environment's view.
interface obi_cache_master_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 64,
  parameter int OP_WIDTH    = 2
);
  // Handshakes: a cmd/rsp transfer happens on a clock edge where valid & ready are
  // both high; a producer holds valid and its payload stable until that edge.
  // OBI A-channel transfers on req & gnt, R-channel on rvalid & rready.
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [OP_WIDTH-1:0]    cmd_op;
  logic [KEY_WIDTH-1:0]   cmd_key;
  logic [VALUE_WIDTH-1:0] cmd_value;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [VALUE_WIDTH-1:0] rsp_value;
  logic                   rsp_err;
  logic                   rsp_timeout;
  logic                   obi_req;
  logic                   obi_gnt;
  logic [ADDR_WIDTH-1:0]  obi_addr;
  logic                   obi_we;
  logic [DATA_WIDTH/8-1:0] obi_be;
  logic [DATA_WIDTH-1:0]  obi_wdata;
  logic                   obi_rvalid;
  logic                   obi_rready;
  logic [DATA_WIDTH-1:0]  obi_rdata;
  logic                   obi_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
    input  obi_gnt, obi_rvalid, obi_rdata, obi_err,
    output cmd_ready, rsp_valid, rsp_value, rsp_err, rsp_timeout,
    output obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_rready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
    output obi_gnt, obi_rvalid, obi_rdata, obi_err,
    input  cmd_ready, rsp_valid, rsp_value, rsp_err, rsp_timeout,
    input  obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_rready
  );
endinterface

// File: rtl/obi_cache_master.sv
// OBI initiator serializing one cache command into single-word OBI beats.
// Optional response timeout: define OBI_CACHE_MASTER_TIMEOUT_EN.
module obi_cache_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 64,
  parameter int OP_WIDTH       = 2,
  parameter int OP_READ        = 1,
  parameter int VALUE_BASE     = 0,
  parameter int KEY_BASE       = 8,
  parameter int OP_ADDR        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  obi_cache_master_if.master     bus,
  output logic [1:0]             o_state
);
  localparam int NV = VALUE_WIDTH / DATA_WIDTH;
  localparam int NK = KEY_WIDTH / DATA_WIDTH;
  localparam int BW = $clog2(2 * NV + NK + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NV + NK);
  localparam logic [BW-1:0] READ_OFS  = BW'(NV);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [OP_WIDTH-1:0]    r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic                   r_is_read;
  logic [BW-1:0]          r_beat;
  logic [VALUE_WIDTH-1:0] r_rsp_value;
  logic                   r_err;
  logic [BW-1:0]          w_vidx;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_we;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic                   w_last;
  logic                   w_abort;

  // Reads skip the value writes, so shifting the beat by NV maps both op kinds
  // onto one sequence: value writes, key writes, op write, value reads.
  assign w_vidx = r_is_read ? (r_beat + READ_OFS) : r_beat;
  assign w_last = (r_beat == LAST_BEAT);

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NV; i++) begin
      if (w_vidx == BW'(i)) begin
        w_we    = 1'b1;
        w_addr  = ADDR_WIDTH'(VALUE_BASE + 4 * i);
        w_wdata = r_value[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_vidx == BW'(NV + NK + 1 + i)) begin
        w_addr = ADDR_WIDTH'(VALUE_BASE + 4 * i);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (w_vidx == BW'(NV + i)) begin
        w_we    = 1'b1;
        w_addr  = ADDR_WIDTH'(KEY_BASE + 4 * i);
        w_wdata = r_key[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (w_vidx == BW'(NV + NK)) begin
      w_we    = 1'b1;
      w_addr  = ADDR_WIDTH'(OP_ADDR);
      w_wdata = DATA_WIDTH'(r_op);
    end
  end

`ifdef OBI_CACHE_MASTER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  assign w_abort = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                   (((r_state == S_ADDR) && !bus.obi_gnt) ||
                    ((r_state == S_RESP) && !bus.obi_rvalid));

  // Restarts on every state entry so each wait for gnt or rvalid is bounded separately.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || !((r_state == S_ADDR) || (r_state == S_RESP))) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.cmd_valid) begin
      r_timeout <= 1'b0;
    end else if (w_abort) begin
      r_timeout <= 1'b1;
    end
  end

  assign bus.rsp_timeout = r_timeout;
`else
  // Without the timeout feature the master waits indefinitely and never aborts.
  assign w_abort         = (TIMEOUT_CYCLES < 0);
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.cmd_valid) w_next = S_ADDR;
      S_ADDR: begin
        if (bus.obi_gnt)  w_next = S_RESP;
        else if (w_abort) w_next = S_DONE;
      end
      S_RESP: begin
        if (bus.obi_rvalid) w_next = w_last ? S_DONE : S_ADDR;
        else if (w_abort)   w_next = S_DONE;
      end
      S_DONE: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.obi_req    = 1'b0;
    bus.obi_addr   = '0;
    bus.obi_we     = 1'b0;
    bus.obi_wdata  = '0;
    bus.obi_rready = 1'b0;
    case (r_state)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_ADDR: begin
        bus.obi_req   = 1'b1;
        bus.obi_addr  = w_addr;
        bus.obi_we    = w_we;
        bus.obi_wdata = w_wdata;
      end
      S_RESP:  bus.obi_rready = 1'b1;
      S_DONE:  bus.rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign bus.obi_be    = '1;
  assign bus.rsp_value = r_rsp_value;
  assign bus.rsp_err   = r_err;
  assign o_state       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_key       <= '0;
      r_value     <= '0;
      r_is_read   <= 1'b0;
      r_beat      <= '0;
      r_rsp_value <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op        <= bus.cmd_op;
            r_key       <= bus.cmd_key;
            r_value     <= bus.cmd_value;
            r_is_read   <= (bus.cmd_op == OP_WIDTH'(OP_READ));
            r_beat      <= '0;
            r_rsp_value <= '0;
            r_err       <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus.obi_rvalid) begin
            r_err <= r_err | bus.obi_err;
            if (!w_last) r_beat <= r_beat + 1'b1;
            for (int i = 0; i < NV; i++) begin
              if (w_vidx == BW'(NV + NK + 1 + i)) begin
                r_rsp_value[i*DATA_WIDTH +: DATA_WIDTH] <= bus.obi_rdata;
              end
            end
          end
        end
        default: ;
      endcase
      if (w_abort) r_err <= 1'b1;
    end
  end
endmodule
